// File: rtl/bip_control_if.sv
// bip_control_if: control bus between the BIP controller and its memories/datapath
interface bip_control_if #(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 16
);
  logic                   start;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]    pc_addr;
  logic [PC_WIDTH-1:0]    operand;
  logic [1:0]             sel_a;
  logic                   sel_b;
  logic                   wr_acc;
  logic                   op;
  logic                   wr_ram;
  logic                   rd_ram;
  logic                   halted;
`ifdef BIP_CYCLE_COUNTER_EN
  logic [15:0]            cycles;
`endif
  modport master (
    output start, instruction,
    input  pc_addr, operand, sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, halted
`ifdef BIP_CYCLE_COUNTER_EN
    , input cycles
`endif
  );
  modport slave (
    input  start, instruction,
    output pc_addr, operand, sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, halted
`ifdef BIP_CYCLE_COUNTER_EN
    , output cycles
`endif
  );
endinterface

// File: rtl/bip_control.sv
// bip_control: BIP program sequencer and instruction decoder; BIP_CYCLE_COUNTER_EN adds a RUN cycle counter
module bip_control #(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 16
) (
  input logic         i_clock,
  input logic         i_reset,
  bip_control_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [4:0]          opcode;
  logic                run;
  logic                is_arith;
  assign opcode   = bus.instruction[INSTR_WIDTH-1 -: 5];
  assign run      = state == RUN;
  assign is_arith = opcode[4:2] == 3'b001;
  assign bus.pc_addr = pc;
  assign bus.operand = bus.instruction[PC_WIDTH-1:0];
  assign bus.halted  = state == HALT;
  // sequencer: start from IDLE, step PC each RUN cycle, park on HLT until reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      case (state)
        IDLE: state <= bus.start ? RUN : IDLE;
        RUN: begin
          state <= opcode == 5'b00000 ? HALT : RUN;
          pc    <= opcode == 5'b00000 ? pc : pc + 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end
  // zero-latency decode, gated so nothing strobes outside RUN
  always_comb begin
    bus.sel_a  = !run ? 2'b00 : is_arith ? 2'b10 : opcode == 5'b00011 ? 2'b01 : 2'b00;
    bus.sel_b  = run & is_arith & opcode[0];
    bus.op     = run & is_arith & opcode[1];
    bus.wr_acc = run & (is_arith | opcode[4:1] == 4'b0001);
    bus.rd_ram = run & (opcode == 5'b00010 | (is_arith & !opcode[0]));
    bus.wr_ram = run & opcode == 5'b00001;
  end
`ifdef BIP_CYCLE_COUNTER_EN
  logic [15:0] cycles;
  assign bus.cycles = cycles;
  // saturating count of edges spent in RUN, HLT cycle included
  always_ff @(posedge i_clock) begin
    if (i_reset) cycles <= '0;
    else if (run && cycles != 16'hFFFF) cycles <= cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: directed self-checking bench for bip_control
module tb_bip_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] mem [2048];
  logic [6:0]  ctl;
  int n_vec = 0;
  int n_err = 0;
  localparam logic [6:0] C_NONE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] C_STO  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] C_LD   = 7'b00_0_1_0_0_1;
  localparam logic [6:0] C_LDI  = 7'b01_0_1_0_0_0;
  localparam logic [6:0] C_ADD  = 7'b10_0_1_0_0_1;
  localparam logic [6:0] C_ADDI = 7'b10_1_1_0_0_0;
  localparam logic [6:0] C_SUB  = 7'b10_0_1_1_0_1;
  localparam logic [6:0] C_SUBI = 7'b10_1_1_1_0_0;
  bip_control_if #(.PC_WIDTH(11), .INSTR_WIDTH(16)) bus ();
  bip_control #(.PC_WIDTH(11), .INSTR_WIDTH(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );
  assign bus.instruction = mem[bus.pc_addr];
  assign ctl = {bus.sel_a, bus.sel_b, bus.wr_acc, bus.op, bus.wr_ram, bus.rd_ram};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_run(input string tag, input logic [10:0] pc, input logic [6:0] c);
    chk({tag, " pc"}, 32'(bus.pc_addr), 32'(pc));
    chk({tag, " ctl"}, 32'(ctl), 32'(c));
    chk({tag, " halted"}, 32'(bus.halted), 32'(0));
  endtask
  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
    mem[0] = 16'h1805;
    mem[1] = 16'h2803;
    mem[2] = 16'h0802;
    mem[3] = 16'h0000;
    step(2);
    expect_run("reset", 11'h000, C_NONE);
`ifdef BIP_CYCLE_COUNTER_EN
    chk("reset cycles", 32'(bus.cycles), 32'(0));
`endif
    rst = 1'b0;
    step(5);
    expect_run("idle", 11'h000, C_NONE);
    chk("idle operand", 32'(bus.operand), 32'h005);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    expect_run("ldi", 11'h000, C_LDI);
    chk("ldi operand", 32'(bus.operand), 32'h005);
    step(1);
    expect_run("addi", 11'h001, C_ADDI);
    chk("addi operand", 32'(bus.operand), 32'h003);
    step(1);
    expect_run("sto", 11'h002, C_STO);
    step(1);
    expect_run("hlt", 11'h003, C_NONE);
    step(1);
    chk("halt pc", 32'(bus.pc_addr), 32'h003);
    chk("halt ctl", 32'(ctl), 32'(C_NONE));
    chk("halt flag", 32'(bus.halted), 32'(1));
`ifdef BIP_CYCLE_COUNTER_EN
    chk("prog a cycles", 32'(bus.cycles), 32'(4));
`endif
    bus.start = 1'b1;
    step(2);
    bus.start = 1'b0;
    chk("halt start pc", 32'(bus.pc_addr), 32'h003);
    chk("halt start flag", 32'(bus.halted), 32'(1));
    chk("halt start ctl", 32'(ctl), 32'(C_NONE));
    rst = 1'b1;
    mem[0] = 16'h3007;
    mem[1] = 16'h3FFF;
    mem[2] = 16'h1000;
    mem[3] = 16'h2004;
    mem[4] = 16'hF800;
    mem[5] = 16'h4000;
    mem[6] = 16'h0000;
    step(1);
    expect_run("reset from halt", 11'h000, C_NONE);
    rst = 1'b0;
    bus.start = 1'b1;
    step(1);
    expect_run("sub", 11'h000, C_SUB);
    chk("sub operand", 32'(bus.operand), 32'h007);
    step(1);
    expect_run("subi", 11'h001, C_SUBI);
    chk("subi operand", 32'(bus.operand), 32'h7FF);
    step(1);
    expect_run("ld", 11'h002, C_LD);
    step(1);
    expect_run("add", 11'h003, C_ADD);
    step(1);
    expect_run("nop 11111", 11'h004, C_NONE);
    step(1);
    expect_run("nop 01000", 11'h005, C_NONE);
    step(1);
    expect_run("hlt b", 11'h006, C_NONE);
    step(1);
    chk("halt b flag", 32'(bus.halted), 32'(1));
    chk("halt b pc", 32'(bus.pc_addr), 32'h006);
`ifdef BIP_CYCLE_COUNTER_EN
    chk("prog b cycles", 32'(bus.cycles), 32'(7));
`endif
    bus.start = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    expect_run("abort sub", 11'h000, C_SUB);
    step(2);
    expect_run("abort ld", 11'h002, C_LD);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_run("abort reset", 11'h000, C_NONE);
    step(1);
    expect_run("abort idle", 11'h000, C_NONE);
    rst = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
    step(1);
    rst = 1'b0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    expect_run("wrap start", 11'h000, C_NONE);
    step(2047);
    expect_run("wrap top", 11'h7FF, C_NONE);
    mem[1] = 16'h0000;
    step(1);
    expect_run("wrap zero", 11'h000, C_NONE);
    step(1);
    expect_run("wrap hlt", 11'h001, C_NONE);
    step(1);
    chk("wrap halted", 32'(bus.halted), 32'(1));
    chk("wrap halt pc", 32'(bus.pc_addr), 32'h001);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
